// File: rtl/warmboot_sequencer.sv
// Fixed-priority arbiter and sequencer driving the SB_WARMBOOT primitive; BOOT rises 1+HOLD+SETUP edges after the request is sampled.
// No backpressure: requesters hold req/req_image level until the sequence commits or aborts.
module warmboot_sequencer #(
    parameter int NREQ         = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_image,
    output logic [NREQ-1:0]   grant,
    output logic              wb_s1,
    output logic              wb_s0,
    output logic              wb_boot,
    output logic              busy,
    output logic              done
);

    localparam int MAXC = (HOLD_CYCLES > SETUP_CYCLES) ?
                          ((HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES) :
                          ((SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES);
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        SETUP = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [1:0]      img_q, img_d;
    logic [1:0]      sel_q, sel_d;
    logic            boot_q, boot_d;

    logic            any_req;
    logic [IDXW-1:0] pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            g_req;
    logic [1:0]      g_img;
    logic            qualifies;

    // Descending scan so the lowest asserted index wins.
    always_comb begin
        pick_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = IDXW'(i);
            end
        end
        any_req = |req;
        pick_oh = NREQ'(1) << pick_idx;
    end

    always_comb begin
        g_req     = req[gidx_q];
        g_img     = req_image[2*int'(gidx_q) +: 2];
        qualifies = enable && g_req && (g_img == img_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        img_d   = img_q;
        sel_d   = sel_q;
        boot_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && any_req) begin
                    state_d = QUAL;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    img_d   = req_image[2*int'(pick_idx) +: 2];
                    cnt_d   = '0;
                end
            end
            QUAL: begin
                if (!qualifies) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = SETUP;
                    sel_d   = img_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SETUP: begin
                if (!enable) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = 2'b00;
                    cnt_d   = '0;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = FIRE;
                    boot_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIRE: begin
                // Committed: enable and req are deliberately not looked at here.
                if (cnt_q == PULSE_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    boot_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            gidx_q  <= '0;
            img_q   <= 2'b00;
            sel_q   <= 2'b00;
            boot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            img_q   <= img_d;
            sel_q   <= sel_d;
            boot_q  <= boot_d;
        end
    end

    assign grant   = grant_q;
    assign wb_s1   = sel_q[1];
    assign wb_s0   = sel_q[0];
    assign wb_boot = boot_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench for warmboot_sequencer: table of {inputs, edges, expected outputs} plus hand-written reset/DONE sequences.
module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] req_image = '0;
    logic [3:0] grant;
    logic       wb_s1, wb_s0, wb_boot, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    warmboot_sequencer #(
        .NREQ(4), .HOLD_CYCLES(16), .SETUP_CYCLES(4), .PULSE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .req_image(req_image),
        .grant(grant), .wb_s1(wb_s1), .wb_s0(wb_s0), .wb_boot(wb_boot),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [8:0] outv = {grant, wb_s1, wb_s0, wb_boot, busy, done};

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [7:0] img;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] o(input logic [3:0] g, input logic [1:0] s,
                                     input logic b, input logic bz, input logic d);
        return {g, s, b, bz, d};
    endfunction

    task automatic add(input string nm, input logic r, input logic e, input logic [3:0] q,
                       input logic [7:0] im, input int n, input logic [8:0] ex);
        vec_t v;
        v.name = nm; v.rst = r; v.en = e; v.req = q; v.img = im; v.n = n; v.exp = ex;
        vecs.push_back(v);
    endtask

    task automatic add_rst(input string nm);
        add({nm, "_rst"}, 1'b1, 1'b0, 4'b0, 8'h00, 1, 9'd0);
        add({nm, "_rel"}, 1'b0, 1'b0, 4'b0, 8'h00, 1, 9'd0);
    endtask

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {grant,s1,s0,boot,busy,done}=%b expected %b", nm, act, exp);
        end
    endtask

    // Counts edges from the current (post-edge) point until wb_boot is seen high.
    task automatic run_to_boot(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (wb_boot) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;

        add_rst("init");
        add("en0_blocks", 0, 0, 4'b0001, 8'h01, 3, 9'd0);
        // Test 1: req[2], image 01, full sequence.
        add("t1_grant",    0, 1, 4'b0100, 8'h10, 1,  o(4'b0100, 2'b00, 0, 1, 0));
        add("t1_qual",     0, 1, 4'b0100, 8'h10, 15, o(4'b0100, 2'b00, 0, 1, 0));
        add("t1_setup",    0, 1, 4'b0100, 8'h10, 1,  o(4'b0100, 2'b01, 0, 1, 0));
        add("t1_setup_e",  0, 1, 4'b0100, 8'h10, 3,  o(4'b0100, 2'b01, 0, 1, 0));
        add("t1_fire1",    0, 1, 4'b0100, 8'h10, 1,  o(4'b0100, 2'b01, 1, 1, 0));
        add("t1_fire2",    0, 1, 4'b0100, 8'h10, 1,  o(4'b0100, 2'b01, 1, 1, 0));
        add("t1_done",     0, 1, 4'b0100, 8'h10, 1,  o(4'b0100, 2'b01, 0, 1, 1));
        add_rst("t1");
        // Test 2: simultaneous req[0]/req[3], lowest index wins.
        add("t2_grant",    0, 1, 4'b1001, 8'hC2, 1,  o(4'b0001, 2'b00, 0, 1, 0));
        add("t2_setup",    0, 1, 4'b1001, 8'hC2, 16, o(4'b0001, 2'b10, 0, 1, 0));
        add("t2_done",     0, 1, 4'b1001, 8'hC2, 6,  o(4'b0001, 2'b10, 0, 1, 1));
        add_rst("t2");
        // Later higher-priority request does not preempt.
        add("pre_grant",   0, 1, 4'b0100, 8'h10, 3,  o(4'b0100, 2'b00, 0, 1, 0));
        add("pre_hold",    0, 1, 4'b0101, 8'h11, 1,  o(4'b0100, 2'b00, 0, 1, 0));
        add_rst("pre");
        // Test 3: partial hold then drop; re-request needs full count.
        add("t3_hold10",   0, 1, 4'b0010, 8'h0C, 10, o(4'b0010, 2'b00, 0, 1, 0));
        add("t3_drop",     0, 1, 4'b0000, 8'h0C, 1,  9'd0);
        add("t3_regrant",  0, 1, 4'b0010, 8'h0C, 1,  o(4'b0010, 2'b00, 0, 1, 0));
        add("t3_partial",  0, 1, 4'b0010, 8'h0C, 15, o(4'b0010, 2'b00, 0, 1, 0));
        add("t3_full",     0, 1, 4'b0010, 8'h0C, 1,  o(4'b0010, 2'b11, 0, 1, 0));
        add("t3_fire",     0, 1, 4'b0010, 8'h0C, 4,  o(4'b0010, 2'b11, 1, 1, 0));
        add_rst("t3");
        // Test 4: image change in QUAL, enable drop in SETUP and in FIRE.
        add("t4_qual",     0, 1, 4'b0001, 8'h01, 5,  o(4'b0001, 2'b00, 0, 1, 0));
        add("t4_imgchg",   0, 1, 4'b0001, 8'h02, 1,  9'd0);
        add("t4_idle",     0, 1, 4'b0000, 8'h01, 1,  9'd0);
        add("t4_setup",    0, 1, 4'b0001, 8'h01, 17, o(4'b0001, 2'b01, 0, 1, 0));
        add("t4_en0_set",  0, 0, 4'b0001, 8'h01, 1,  9'd0);
        add("t4_en0_idle", 0, 0, 4'b0001, 8'h01, 2,  9'd0);
        add("t4_grant",    0, 1, 4'b0001, 8'h01, 1,  o(4'b0001, 2'b00, 0, 1, 0));
        add("t4_fire",     0, 1, 4'b0001, 8'h01, 20, o(4'b0001, 2'b01, 1, 1, 0));
        add("t4_en0_fire", 0, 0, 4'b0000, 8'h00, 1,  o(4'b0001, 2'b01, 1, 1, 0));
        add("t4_fire_end", 0, 0, 4'b0000, 8'h00, 1,  o(4'b0001, 2'b01, 0, 1, 1));

        @(posedge clk); #1;
        foreach (vecs[k]) begin
            rst       = vecs[k].rst;
            enable    = vecs[k].en;
            req       = vecs[k].req;
            req_image = vecs[k].img;
            repeat (vecs[k].n) @(posedge clk);
            #1;
            check(vecs[k].name, outv, vecs[k].exp);
        end

        // Test 6: DONE is terminal regardless of req/enable activity.
        for (int i = 0; i < 100; i++) begin
            enable    = 1'($urandom);
            req       = 4'($urandom);
            req_image = 8'($urandom);
            @(posedge clk); #1;
            check("t6_done_hold", outv, o(4'b0001, 2'b01, 0, 1, 1));
        end

        // Test 5: async reset mid-FIRE, then a full new sequence.
        rst = 1'b1; enable = 1'b0; req = '0; req_image = '0;
        @(posedge clk); #1;
        rst = 1'b0; enable = 1'b1; req = 4'b0100; req_image = 8'h20;
        run_to_boot(lat);
        n_cmp++;
        if (lat != 21) begin
            n_bad++;
            $display("FAIL t5_latency: got %0d edges expected 21", lat);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_rst", outv, 9'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_to_boot(lat);
        n_cmp++;
        if (lat != 21) begin
            n_bad++;
            $display("FAIL t5_relatency: got %0d edges expected 21", lat);
        end
        check("t5_fire", outv, o(4'b0100, 2'b10, 1, 1, 0));
        repeat (2) @(posedge clk);
        #1;
        check("t5_done", outv, o(4'b0100, 2'b10, 0, 1, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
